// File: rtl/if_stage1_pkg.sv
// Shared bus widths and record layouts for the IF1 fetch stage.
// Field order matches the {pc_valid, pc_is_jump, pc, rdata} packing used by IF0 and IF2.
package if_stage1_pkg;

    localparam int IF0_TO_IF1_BUS_WD = 40;
    localparam int IF1_TO_IF2_BUS_WD = 168;
    localparam int FETCH_DATA_WD     = 128;

    typedef struct packed {
        logic [3:0]  pc_valid;
        logic [3:0]  pc_is_jump;
        logic [31:0] pc;
    } if0_req_t;

    typedef struct packed {
        if0_req_t                 req;
        logic [FETCH_DATA_WD-1:0] rdata;
    } fetch_group_t;

    function automatic fetch_group_t make_group(input if0_req_t req,
                                                input logic [FETCH_DATA_WD-1:0] rdata);
        fetch_group_t grp;
        grp.req   = req;
        grp.rdata = rdata;
        return grp;
    endfunction

endpackage

// File: rtl/if_stage1_if.sv
// Handshake bundle between IF0, the icache response path, IF1 and IF2.
// The slave view belongs to if_stage1; the master view to whatever drives it.
interface if_stage1_if;
    import if_stage1_pkg::*;

    logic                         flush_IF;
    logic [IF0_TO_IF1_BUS_WD-1:0] if0_if1_bus;
    logic                         IF0_valid;
    logic                         IF1_ready;
    logic                         addr_ok;
    logic [FETCH_DATA_WD-1:0]     rdata;
    logic                         data_ok;
    logic [IF1_TO_IF2_BUS_WD-1:0] if1_if2_bus;
    logic                         IF1_valid;
    logic                         IF2_ready;

    modport slave (
        input  flush_IF, if0_if1_bus, IF0_valid, addr_ok, rdata, data_ok, IF2_ready,
        output IF1_ready, if1_if2_bus, IF1_valid
    );

    modport master (
        output flush_IF, if0_if1_bus, IF0_valid, addr_ok, rdata, data_ok, IF2_ready,
        input  IF1_ready, if1_if2_bus, IF1_valid
    );

endinterface

// File: rtl/if_stage1_fetch_fifo.sv
// Small circular FIFO used for both the fetch metadata queue and the result buffer.
// A clear drops every entry at once and takes priority over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_stage1.sv
// IF1 fetch stage: limits outstanding icache requests, pairs returning data with its pc
// metadata, buffers finished fetch groups for IF2 and discards responses orphaned by a flush.
module if_stage1
    import if_stage1_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage1_if.slave  fetch_if
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 2;

    logic          issue_d_q, issue_d_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] meta_count, res_count;
    logic          meta_full, meta_empty, res_full, res_empty;
    logic [OW-1:0] occupancy, pending;
    logic          ready, issue, flush;
    logic          resp_live, resp_drop, resp_deliver;
    logic          meta_capture, meta_push, meta_pop, bypass;
    logic          res_pop;
    if0_req_t      meta_head, pair_req;
    fetch_group_t  res_in, res_head;
    logic          unused_fifo_status;

    assign flush     = fetch_if.flush_IF;
    assign pending   = OW'(inflight_q) + OW'(discard_q);
    assign occupancy = pending + OW'(res_count);

    // Every slot is reserved at issue time, so the result buffer can never overflow.
    assign ready = (occupancy < OW'(FIFO_DEPTH));
    assign issue = ready && fetch_if.addr_ok;

    assign resp_live    = fetch_if.data_ok && !flush;
    assign resp_drop    = resp_live && (discard_q != '0);
    assign resp_deliver = resp_live && (discard_q == '0) && (inflight_q != '0);

    assign meta_capture = issue_d_q && fetch_if.IF0_valid && !flush;
    assign bypass       = resp_deliver && meta_capture && meta_empty;
    assign meta_push    = meta_capture && !bypass;
    assign meta_pop     = resp_deliver && !meta_empty;

    assign pair_req = bypass ? if0_req_t'(fetch_if.if0_if1_bus) : meta_head;
    assign res_in   = make_group(pair_req, fetch_if.rdata);
    assign res_pop  = !res_empty && fetch_if.IF2_ready;

    assign fetch_if.IF1_ready   = ready;
    assign fetch_if.IF1_valid   = !res_empty;
    assign fetch_if.if1_if2_bus = res_empty ? '0 : res_head;

    assign unused_fifo_status = ^{meta_full, meta_count, res_full};

    // A flush turns everything still owed by the cache into responses to be thrown away.
    always_comb begin
        inflight_d = inflight_q;
        discard_d  = discard_q;
        issue_d_d  = issue;
        if (flush) begin
            inflight_d = '0;
            discard_d  = CW'(pending + OW'(issue) - OW'(fetch_if.data_ok && (pending != '0)));
        end else begin
            if (issue)        inflight_d = inflight_d + CW'(1);
            if (resp_deliver) inflight_d = inflight_d - CW'(1);
            if (resp_drop)    discard_d  = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_d_q  <= 1'b0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            issue_d_q  <= issue_d_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(if0_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (meta_push),
        .data_i  (fetch_if.if0_if1_bus),
        .pop_i   (meta_pop),
        .data_o  (meta_head),
        .full_o  (meta_full),
        .empty_o (meta_empty),
        .count_o (meta_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_group_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (resp_deliver),
        .data_i  (res_in),
        .pop_i   (res_pop),
        .data_o  (res_head),
        .full_o  (res_full),
        .empty_o (res_empty),
        .count_o (res_count)
    );

endmodule

// File: tb/tb_if_stage1.sv
// Directed bench for if_stage1: a queue-based model of the stage checked every cycle,
// plus hand-computed expectations for the key scenarios and a streaming run on a 4-deep copy.
module tb_if_stage1;

    localparam int DEPTH = 2;
    localparam logic [127:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int compared   = 0;
    int mismatched = 0;

    if_stage1_if fif ();
    if_stage1_if sif4 ();

    if_stage1 #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (fif)
    );

    if_stage1 #(.FIFO_DEPTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (sif4)
    );

    always #5 clk = ~clk;

    // Model state: outstanding requests, responses to throw away, pc records, finished groups.
    int           mInflight = 0;
    int           mDiscard  = 0;
    bit           mIssueD   = 1'b0;
    logic [39:0]  mMeta[$];
    logic [167:0] mRes[$];

    function automatic logic [127:0] mkData(input logic [31:0] pc);
        return {pc + 32'hC, pc + 32'h8, pc + 32'h4, pc};
    endfunction

    function automatic logic [167:0] grp(input logic [31:0] pc);
        return {8'hF0, pc, mkData(pc)};
    endfunction

    task automatic checkOutput(input string name, input logic [167:0] act, input logic [167:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        bit          iss;
        bit          cap;
        int          tot;
        logic [39:0] req;
        iss = ((mInflight + mDiscard + mRes.size()) < DEPTH) && fif.addr_ok;
        if (fif.flush_IF) begin
            tot       = mInflight + mDiscard;
            mDiscard  = tot + int'(iss) - ((fif.data_ok && tot > 0) ? 1 : 0);
            mInflight = 0;
            mMeta.delete();
            mRes.delete();
        end else begin
            cap = mIssueD && fif.IF0_valid;
            if (mRes.size() != 0 && fif.IF2_ready) void'(mRes.pop_front());
            if (fif.data_ok && mDiscard > 0) begin
                mDiscard--;
            end else if (fif.data_ok && mInflight > 0) begin
                if (cap && mMeta.size() == 0) begin
                    req = fif.if0_if1_bus;
                    cap = 1'b0;
                end else begin
                    req = mMeta.pop_front();
                end
                mRes.push_back({req, fif.rdata});
                mInflight--;
            end
            if (cap) mMeta.push_back(fif.if0_if1_bus);
            if (iss) mInflight++;
        end
        mIssueD = iss;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mInflight = 0;
                mDiscard  = 0;
                mIssueD   = 1'b0;
                mMeta.delete();
                mRes.delete();
            end else begin
                modelStep();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_ready", fif.IF1_ready, (mInflight + mDiscard + mRes.size()) < DEPTH);
            checkOutput("model_valid", fif.IF1_valid, mRes.size() != 0);
            checkOutput("model_bus", fif.if1_if2_bus, (mRes.size() != 0) ? mRes[0] : '0);
        end
    end

    task automatic idleInputs();
        fif.flush_IF     = 1'b0;
        fif.if0_if1_bus  = '0;
        fif.IF0_valid    = 1'b0;
        fif.addr_ok      = 1'b0;
        fif.rdata        = '0;
        fif.data_ok      = 1'b0;
        fif.IF2_ready    = 1'b0;
        sif4.flush_IF    = 1'b0;
        sif4.if0_if1_bus = '0;
        sif4.IF0_valid   = 1'b0;
        sif4.addr_ok     = 1'b0;
        sif4.rdata       = '0;
        sif4.data_ok     = 1'b0;
        sif4.IF2_ready   = 1'b0;
    endtask

    // One cycle of IF0 / icache / IF2 activity, applied just after a falling edge.
    task automatic applyStimulus(input bit aok, input bit v0, input logic [31:0] pc,
                                 input bit dok, input logic [127:0] rd,
                                 input bit rdy, input bit fl);
        fif.addr_ok     = aok;
        fif.IF0_valid   = v0;
        fif.if0_if1_bus = v0 ? {8'hF0, pc} : '0;
        fif.data_ok     = dok;
        fif.rdata       = dok ? rd : '0;
        fif.IF2_ready   = rdy;
        fif.flush_IF    = fl;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] prevPc;
        idleInputs();
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", fif.IF1_valid, 1'b0);
        checkOutput("reset_ready", fif.IF1_ready, 1'b1);
        checkOutput("reset_bus", fif.if1_if2_bus, '0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single fetch with bypass");
        applyStimulus(1, 0, 32'h0, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h1c000000, 1, mkData(32'h1c000000), 1, 0);
        checkOutput("single_valid", fif.IF1_valid, 1'b1);
        checkOutput("single_bus", fif.if1_if2_bus,
                    {8'hF0, 32'h1c000000, 128'h1c00000c_1c000008_1c000004_1c000000});
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);
        checkOutput("single_one_cycle", fif.IF1_valid, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(1, 0, 32'h0, 0, '0, 0, 0);
        applyStimulus(1, 1, 32'h1c000010, 1, mkData(32'h1c000010), 0, 0);
        applyStimulus(0, 1, 32'h1c000020, 1, mkData(32'h1c000020), 0, 0);
        checkOutput("bp_full_ready", fif.IF1_ready, 1'b0);
        checkOutput("bp_head", fif.if1_if2_bus, grp(32'h1c000010));
        applyStimulus(0, 0, 32'h0, 0, '0, 0, 0);
        checkOutput("bp_head_stable", fif.if1_if2_bus, grp(32'h1c000010));
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);
        checkOutput("bp_second", fif.if1_if2_bus, grp(32'h1c000020));
        checkOutput("bp_ready_again", fif.IF1_ready, 1'b1);
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);
        checkOutput("bp_drained", fif.IF1_valid, 1'b0);

        $display("[TB] metadata queue pairing");
        applyStimulus(1, 0, 32'h0, 0, '0, 1, 0);
        applyStimulus(1, 1, 32'h1c000030, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h1c000034, 1, mkData(32'h1c000030), 1, 0);
        checkOutput("meta_first", fif.if1_if2_bus, grp(32'h1c000030));
        applyStimulus(0, 0, 32'h0, 1, mkData(32'h1c000034), 1, 0);
        checkOutput("meta_second", fif.if1_if2_bus, grp(32'h1c000034));
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);

        $display("[TB] flush with two in flight");
        applyStimulus(1, 0, 32'h0, 0, '0, 1, 0);
        applyStimulus(1, 1, 32'h1c000040, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h1c000080, 0, '0, 1, 1);
        checkOutput("flush_ready_blocked", fif.IF1_ready, 1'b0);
        applyStimulus(0, 0, 32'h0, 1, JUNK, 1, 0);
        checkOutput("flush_drop1", fif.IF1_valid, 1'b0);
        applyStimulus(1, 0, 32'h0, 1, JUNK, 1, 0);
        checkOutput("flush_drop2", fif.IF1_valid, 1'b0);
        applyStimulus(0, 1, 32'h1c000100, 1, mkData(32'h1c000100), 1, 0);
        checkOutput("flush_third", fif.if1_if2_bus, grp(32'h1c000100));
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);

        $display("[TB] flush with coincident response and issue");
        applyStimulus(1, 0, 32'h0, 0, '0, 1, 0);
        applyStimulus(1, 1, 32'h1c000200, 1, mkData(32'h1c000200), 1, 1);
        checkOutput("coflush_valid", fif.IF1_valid, 1'b0);
        checkOutput("coflush_ready", fif.IF1_ready, 1'b1);
        applyStimulus(0, 0, 32'h0, 1, JUNK, 1, 0);
        checkOutput("coflush_dropped", fif.IF1_valid, 1'b0);
        applyStimulus(0, 0, 32'h0, 0, '0, 1, 0);

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(1, 0, 32'h0, 0, '0, 1, 0);
        applyStimulus(0, 1, 32'h1c000300, 1, mkData(32'h1c000300), 0, 0);
        checkOutput("areset_pre_valid", fif.IF1_valid, 1'b1);
        idleInputs();
        #3 rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", fif.IF1_valid, 1'b0);
        checkOutput("areset_bus", fif.if1_if2_bus, '0);
        checkOutput("areset_ready", fif.IF1_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("areset_release_ready", fif.IF1_ready, 1'b1);
        checkOutput("areset_release_valid", fif.IF1_valid, 1'b0);

        $display("[TB] streaming on the 4-deep instance");
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) checkOutput("stream_ready", sif4.IF1_ready, 1'b1);
            prevPc           = 32'h1c001000 + 32'(16 * (k - 1));
            sif4.addr_ok     = (k < 8);
            sif4.IF0_valid   = (k > 0);
            sif4.if0_if1_bus = (k > 0) ? {8'hF0, prevPc} : '0;
            sif4.data_ok     = (k > 0);
            sif4.rdata       = (k > 0) ? mkData(prevPc) : '0;
            sif4.IF2_ready   = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                checkOutput("stream_valid", sif4.IF1_valid, 1'b1);
                checkOutput("stream_head", sif4.if1_if2_bus, grp(prevPc));
            end
        end
        idleInputs();
        sif4.IF2_ready = 1'b1;
        @(negedge clk);
        checkOutput("stream_drained", sif4.IF1_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
